riscv_dmem_responder: RTL and testbench
=======================================

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data and address width in bits.
REQ-002 Parameter DEPTH_WORDS, default 256, power of two: number of DATA_WIDTH words stored; AW = log2(DEPTH_WORDS).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 data_addr  input  DATA_WIDTH  byte address from the pipeline MEM stage.
REQ-006 data_wdata  input  DATA_WIDTH  store data.
REQ-007 data_we  input  1  store request, sampled every cycle.
REQ-008 data_re  input  1  load request; tie high if the initiator has no read strobe.
REQ-009 data_rdata  output  DATA_WIDTH  load data, combinational from data_addr.
REQ-010 mem_ready  output  1  high once the clear sweep is complete.
REQ-011 err_code  output  2  sticky errors: bit0 misaligned, bit1 out of range.
REQ-012 err_clr  input  1  synchronous clear of err_code.
REQ-013 wr_count  output  16  number of accepted stores, saturating.

Function
REQ-014 The block SHALL implement a two-state FSM: S_INIT and S_READY.
REQ-015 S_INIT SHALL write zero to word init_ptr each cycle, init_ptr counting 0 to DEPTH_WORDS-1, then transition to S_READY on the cycle after writing word DEPTH_WORDS-1 (init takes exactly DEPTH_WORDS cycles).
REQ-016 S_READY SHALL be terminal until reset.
REQ-017 mem_ready SHALL equal 1 exactly when the state is S_READY.
REQ-018 In S_INIT, data_rdata SHALL be 0, stores SHALL be ignored, err_code and wr_count SHALL not change.
REQ-019 An access SHALL be aligned iff data_addr[1:0] == 0 and in range iff data_addr < 4*DEPTH_WORDS (unsigned); word index = data_addr[AW+1:2].
REQ-020 In S_READY, data_rdata SHALL equal the stored word at the word index with zero latency when data_re=1 and the access is aligned and in range; otherwise data_rdata SHALL be 0.
REQ-021 In S_READY, a store (data_we=1, aligned, in range) SHALL update the word at the rising edge; the new value is visible on data_rdata from the next cycle.
REQ-022 Simultaneous data_we and data_re to the same word SHALL return the old word that cycle (read before write).
REQ-023 A store that is misaligned or out of range SHALL not modify memory and SHALL not increment wr_count.
REQ-024 In S_READY, when data_we or data_re is high, err_code bit0 SHALL set on misalignment and bit1 on out-of-range; both may set in one cycle.
REQ-025 err_code bits SHALL remain set until err_clr=1; if err_clr and a new error occur in the same cycle, the new error bit SHALL be set after the edge (set wins).
REQ-026 wr_count SHALL increment by 1 per accepted store and saturate at 16'hFFFF.
REQ-027 Memory contents SHALL not be altered except by the init sweep and accepted stores.

Reset
REQ-028 On reset assertion: state=S_INIT, init_ptr=0, mem_ready=0, err_code=0, wr_count=0, data_rdata=0, regardless of clock.
REQ-029 Reset asserted mid-sweep or in S_READY SHALL restart the full sweep from word 0 after deassertion.

Verification
REQ-030 Reset, DEPTH_WORDS=256 -> mem_ready=0 for 256 cycles, 1 from cycle 257; every word reads 0.
REQ-031 Store 0xDEADBEEF to 0x10, then load 0x10 -> data_rdata=0xDEADBEEF next cycle, wr_count=1, err_code=0.
REQ-032 Store to 0x13 and load from 0x400 (DEPTH 256) -> err_code=2'b11, memory unchanged, wr_count unchanged, data_rdata=0 for 0x400.
REQ-033 err_clr=1 with a new misaligned store in the same cycle -> err_code=2'b01 after the edge; err_clr alone next cycle -> 2'b00.
REQ-034 Reset pulse at sweep cycle 100, then store attempts during the restarted sweep -> stores ignored, sweep restarts at 0, mem_ready rises 256 cycles after deassertion.
REQ-035 70000 accepted stores -> wr_count holds 16'hFFFF.

Source files
------------

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder
// Word-organised data memory that answers a RISC-V MEM stage. After reset it
// zeroes every word with a one-word-per-cycle sweep, then serves zero-latency
// loads and single-cycle stores, flags misaligned/out-of-range accesses in a
// sticky error register, and counts accepted stores.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   data_addr   byte address from the MEM stage
//   data_wdata  store data
//   data_we     store request, sampled every cycle
//   data_re     load request (tie high if the initiator has no read strobe)
//   data_rdata  load data, combinational from data_addr
//   mem_ready   high once the clear sweep has finished
//   err_code    sticky errors: bit0 misaligned, bit1 out of range
//   err_clr     synchronous clear of err_code
//   wr_count    accepted-store count, saturating at 16'hFFFF
//   fsm_state   current FSM state (0 = S_INIT, 1 = S_READY) for observation
//
// Handshake: there is no backpressure. A request is a single-cycle strobe
// (data_we / data_re) qualified by data_addr; a load answers in the same
// cycle, a store commits on the rising edge that ends the cycle.
module riscv_dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_we,
  input  logic                  data_re,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_ready,
  output logic [1:0]            err_code,
  input  logic                  err_clr,
  output logic [15:0]           wr_count,
  output logic                  fsm_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   init_ptr_q, init_ptr_d;
  logic            init_wr;
  logic [1:0]      err_q, err_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic          ready;
  logic          aligned;
  logic          in_range;
  logic          access;
  logic          store_ok;
  logic          load_ok;
  logic [AW-1:0] word_idx;
  logic [1:0]    err_set;

  // Address decode. In range means every bit above the word-index field is
  // zero, i.e. data_addr < 4*DEPTH_WORDS.
  assign ready    = (state_q == S_READY);
  assign aligned  = (data_addr[1:0] == 2'b00);
  assign in_range = ((data_addr >> (AW + 2)) == '0);
  assign word_idx = data_addr[AW+1:2];
  assign access   = data_we | data_re;
  assign store_ok = ready & data_we & aligned & in_range;
  assign load_ok  = ready & data_re & aligned & in_range;
  assign err_set  = {access & ~in_range, access & ~aligned};

  // Combinational read of the pre-edge contents gives read-before-write when
  // a load and a store hit the same word in one cycle.
  assign data_rdata = load_ok ? mem[word_idx] : '0;
  assign mem_ready  = ready;
  assign err_code   = err_q;
  assign wr_count   = wr_count_q;
  assign fsm_state  = state_q;

  // State / counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      err_q      <= 2'b00;
      wr_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    init_wr    = 1'b0;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    case (state_q)
      S_INIT: begin
        init_wr = 1'b1;
        // The edge that zeroes the last word also moves us to S_READY.
        if (init_ptr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = S_READY;
        end else begin
          init_ptr_d = init_ptr_q + AW'(1);
        end
      end
      S_READY: begin
        // Clear first, then OR in this cycle's errors: a new error wins.
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
        if (store_ok && (wr_count_q != 16'hFFFF)) begin
          wr_count_d = wr_count_q + 16'd1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Storage has no reset; the sweep is what clears it. The sweep write is
  // held off while reset is asserted so words are only touched after release.
  always_ff @(posedge clk) begin
    if (init_wr && !reset) begin
      mem[init_ptr_q] <= '0;
    end else if (store_ok) begin
      mem[word_idx] <= data_wdata;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder
// Directed bench for riscv_dmem_responder (DATA_WIDTH 32, DEPTH_WORDS 256):
// reset/sweep timing, store/load, read-before-write, error flags and clear,
// reset during the sweep, and wr_count saturation.
module tb_riscv_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_we;
  logic        data_re;
  logic [31:0] data_rdata;
  logic        mem_ready;
  logic [1:0]  err_code;
  logic        err_clr;
  logic [15:0] wr_count;
  logic        fsm_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  riscv_dmem_responder #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(256)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_we   (data_we),
    .data_re   (data_re),
    .data_rdata(data_rdata),
    .mem_ready (mem_ready),
    .err_code  (err_code),
    .err_clr   (err_clr),
    .wr_count  (wr_count),
    .fsm_state (fsm_state)
  );

  // One rising edge, returning on the following falling edge (drive point).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    data_re   = 1'b1;
    data_addr = 32'h0;
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got %0b expected 0", mem_ready); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_err_code got %b expected 00", err_code); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL rst_wr_count got %h expected 0000", wr_count); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h expected 00000000", data_rdata); end
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL rst_fsm_state got %0b expected 0", fsm_state); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 256; c++) begin
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready_low cycle %0d got %0b expected 0", c + 1, mem_ready); end
      checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL sweep_rdata cycle %0d got %h expected 00000000", c + 1, data_rdata); end
      step();
    end
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready_high got %0b expected 1", mem_ready); end
    for (int w = 0; w < 256; w++) begin
      data_addr = 32'(w * 4);
      #1;
      checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL swept_word %0d got %h expected 00000000", w, data_rdata); end
    end
    data_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    data_addr  = 32'h10;
    data_wdata = 32'hDEADBEEF;
    data_we    = 1'b1;
    data_re    = 1'b0;
    step();
    data_we = 1'b0;
    data_re = 1'b1;
    #1;
    checks++; if (data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_0x10 got %h expected deadbeef", data_rdata); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL store_count got %h expected 0001", wr_count); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL store_err got %b expected 00", err_code); end
    // Same-word load and store: old data this cycle, new data next cycle.
    data_we    = 1'b1;
    data_wdata = 32'h12345678;
    #1;
    checks++; if (data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rbw_old got %h expected deadbeef", data_rdata); end
    step();
    data_we = 1'b0;
    #1;
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("FAIL rbw_new got %h expected 12345678", data_rdata); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL rbw_count got %h expected 0002", wr_count); end
    data_re = 1'b0;
    #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL no_re_rdata got %h expected 00000000", data_rdata); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    data_addr  = 32'h13;
    data_wdata = 32'hFFFFFFFF;
    data_we    = 1'b1;
    step();
    data_we = 1'b0;
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL misalign_err got %b expected 01", err_code); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL misalign_count got %h expected 0002", wr_count); end
    data_addr = 32'h400;
    data_re   = 1'b1;
    #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h expected 00000000", data_rdata); end
    step();
    checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL both_err got %b expected 11", err_code); end
    data_addr = 32'h10;
    #1;
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("FAIL misalign_unchanged got %h expected 12345678", data_rdata); end
    data_addr = 32'h80000010;
    #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL high_addr_rdata got %h expected 00000000", data_rdata); end
    // Aligned but out of range: must not alias onto word 0.
    data_re    = 1'b0;
    data_addr  = 32'h400;
    data_wdata = 32'hCAFEF00D;
    data_we    = 1'b1;
    step();
    data_we   = 1'b0;
    data_re   = 1'b1;
    data_addr = 32'h0;
    #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL oor_store_word0 got %h expected 00000000", data_rdata); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL oor_store_count got %h expected 0002", wr_count); end
    data_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_clr();
    err_clr    = 1'b1;
    data_addr  = 32'h21;
    data_wdata = 32'h1;
    data_we    = 1'b1;
    step();
    data_we = 1'b0;
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL clr_set_wins got %b expected 01", err_code); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL clr_count got %h expected 0002", wr_count); end
    step();
    err_clr = 1'b0;
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL clr_alone got %b expected 00", err_code); end
    // Misaligned address with no strobe is not an access.
    step();
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL idle_no_err got %b expected 00", err_code); end
  endtask

  task automatic test_reset_mid_sweep();
    data_addr = 32'h11;
    data_re   = 1'b1;
    step();
    checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL load_misalign_err got %b expected 01", err_code); end
    data_addr = 32'h10;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL async_wr_count got %h expected 0000", wr_count); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL async_err got %b expected 00", err_code); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %0b expected 0", mem_ready); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL async_rdata got %h expected 00000000", data_rdata); end
    @(negedge clk);
    reset = 1'b0;
    repeat (100) step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL sweep100_ready got %0b expected 0", mem_ready); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL sweep100_state got %0b expected 0", fsm_state); end
    @(negedge clk);
    reset = 1'b0;
    data_wdata = 32'hA5A5A5A5;
    data_we    = 1'b1;
    for (int c = 0; c < 256; c++) begin
      data_addr = (c % 2 == 1) ? 32'h11 : 32'h10;
      #1;
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL resweep_ready cycle %0d got %0b expected 0", c + 1, mem_ready); end
      checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL resweep_rdata cycle %0d got %h expected 00000000", c + 1, data_rdata); end
      step();
    end
    data_we   = 1'b0;
    data_addr = 32'h10;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL resweep_ready_high got %0b expected 1", mem_ready); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL resweep_word got %h expected 00000000", data_rdata); end
    checks++; if (wr_count !== 16'h0) begin errors++; $display("FAIL resweep_count got %h expected 0000", wr_count); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL resweep_err got %b expected 00", err_code); end
    data_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    data_addr = 32'h20;
    data_we   = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      data_wdata = 32'(i);
      step();
      if (i == 65533) begin
        checks++; if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h expected fffe", wr_count); end
      end
    end
    data_we = 1'b0;
    data_re = 1'b1;
    #1;
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h expected ffff", wr_count); end
    checks++; if (data_rdata !== 32'd69999) begin errors++; $display("FAIL sat_last_data got %h expected %h", data_rdata, 32'd69999); end
    data_re = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_we    = 1'b0;
    data_re    = 1'b0;
    err_clr    = 1'b0;
    test_reset();
    test_store_load();
    test_errors();
    test_err_clr();
    test_reset_mid_sweep();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
